fetch_sequencer: RTL and testbench

- Owns the program counter and sequences the 2-stage fetch/execute pipeline: fetch (F) and execute (EX).
- Each cycle it chooses the next fetch address from four sources: sequential PC+1, branch_addr, jal_addr or jalr_addr. The decoder computes all three targets.
- Evaluates conditional branches and squashes the wrong-path instruction on a redirect.
- Handles stall and halt/resume, and keeps a retired-instruction counter.
- Sits between the instruction memory (synchronous read, 1-cycle latency, word-addressed, 4096 words) and instruction_decoder / regfile.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/branch_compare.sv | 43 ++++
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: opcode and funct3 encodings of
// the control-transfer instructions, the fetch sequencer state type and the
// default program-counter width.
package cpu_pkg;

  localparam int DEFAULT_PC_W = 12;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/branch_compare.sv
// Conditional-branch comparator.
// Purely combinational. For a given funct3 it reports whether the branch
// condition holds and whether the funct3 is one of the reserved encodings.
//   funct3   : branch kind of the EX instruction
//   rs1_data : first source operand
//   rs2_data : second source operand
//   cond     : branch condition holds (always 0 for reserved encodings)
//   illegal  : funct3 is 010 or 011
module branch_compare
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        cond,
  output logic        illegal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_data == rs2_data);
  assign lt_s = ($signed(rs1_data) < $signed(rs2_data));
  assign lt_u = (rs1_data < rs2_data);

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves it unassigned; an unassigned path would infer a latch.
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = ~eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = ~lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = ~lt_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer for the 2-stage fetch (F) / execute (EX) pipeline.
// Owns the program counter, picks the next fetch address (sequential,
// branch, JAL or JALR target), squashes the wrong-path word on a taken
// control transfer, handles stall and halt/resume, and counts retired
// instructions.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   stall          : freeze the whole pipeline this cycle
//   halt_req       : stop fetching after the EX instruction completes
//   resume         : leave HALT
//   opcode_ex      : opcode of the EX instruction
//   funct3_ex      : funct3 of the EX instruction
//   rs1_data       : first register operand of the EX instruction
//   rs2_data       : second register operand of the EX instruction
//   branch_addr    : conditional-branch target
//   jal_addr       : JAL target
//   jalr_addr      : JALR target
//   pc_f           : instruction-memory read address
//   pc_ex          : PC of the instruction in EX
//   ex_valid       : EX holds a real, non-squashed instruction
//   redirect       : taken control transfer this cycle
//   link_addr      : pc_ex + 1, return address for JAL/JALR
//   illegal_branch : EX branch uses a reserved funct3
//   halted         : sequencer is in HALT
//   instret        : retired-instruction count
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = DEFAULT_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  input  logic [6:0]       opcode_ex,
  input  logic [2:0]       funct3_ex,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic [PC_W-1:0]  branch_addr,
  input  logic [PC_W-1:0]  jal_addr,
  input  logic [PC_W-1:0]  jalr_addr,
  output logic [PC_W-1:0]  pc_f,
  output logic [PC_W-1:0]  pc_ex,
  output logic             ex_valid,
  output logic             redirect,
  output logic [PC_W-1:0]  link_addr,
  output logic             illegal_branch,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [PC_W-1:0]  pc_f_d;
  logic [PC_W-1:0]  pc_ex_d;
  logic             ex_valid_d;
  logic [CNT_W-1:0] instret_d;

  logic             is_branch;
  logic             is_jal;
  logic             is_jalr;
  logic             cond;
  logic             illegal;
  logic             take_ex;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  fetch_next;

  branch_compare u_branch_compare (
    .funct3   (funct3_ex),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .cond     (cond),
    .illegal  (illegal)
  );

  assign is_branch = (opcode_ex == OPC_BRANCH);
  assign is_jal    = (opcode_ex == OPC_JAL);
  assign is_jalr   = (opcode_ex == OPC_JALR);

  assign take_ex        = ex_valid & (is_jal | is_jalr | (is_branch & cond));
  assign redirect       = take_ex & ~stall & (state_q == RUN);
  assign illegal_branch = ex_valid & is_branch & illegal;

  assign target = is_jal  ? jal_addr  :
                  is_jalr ? jalr_addr :
                            branch_addr;

  // Sequential fetch wraps modulo 2^PC_W through plain truncation.
  assign fetch_next = redirect ? target : pc_f + PC_W'(1);

  assign link_addr = pc_ex + PC_W'(1);
  assign halted    = (state_q == HALT);

  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f;
    pc_ex_d    = pc_ex;
    ex_valid_d = ex_valid;
    instret_d  = instret;
    case (state_q)
      RUN: begin
        if (!stall) begin
          pc_ex_d   = pc_f;
          pc_f_d    = fetch_next;
          instret_d = instret + CNT_W'(ex_valid);
          if (halt_req) begin
            // The EX instruction still completes; fetch_next is the
            // address execution resumes from.
            state_d    = HALT;
            ex_valid_d = 1'b0;
          end else begin
            // A redirect squashes the word currently being read.
            ex_valid_d = ~redirect;
          end
        end
      end
      HALT: begin
        // Stall is ignored here. After resume, ex_valid stays low for one
        // cycle while memory delivers the word at the resume point.
        ex_valid_d = 1'b0;
        if (resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_f     <= RESET_PC;
      pc_ex    <= RESET_PC;
      ex_valid <= 1'b0;
      instret  <= '0;
    end else begin
      state_q  <= state_d;
      pc_f     <= pc_f_d;
      pc_ex    <= pc_ex_d;
      ex_valid <= ex_valid_d;
      instret  <= instret_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed per-cycle vectors. Each vector
// drives the inputs just after a rising edge and pushes the hand-computed
// expected outputs into a scoreboard queue; a separate monitor pops and
// compares on the falling edge. An expected value of -1 means "not checked".
module tb_fetch_sequencer;
  import cpu_pkg::*;

  localparam int PC_W  = 12;
  localparam int CNT_W = 32;
  localparam longint D = -1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall;
  logic             halt_req;
  logic             resume;
  logic [6:0]       opcode_ex;
  logic [2:0]       funct3_ex;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic [PC_W-1:0]  branch_addr;
  logic [PC_W-1:0]  jal_addr;
  logic [PC_W-1:0]  jalr_addr;
  logic [PC_W-1:0]  pc_f;
  logic [PC_W-1:0]  pc_ex;
  logic             ex_valid;
  logic             redirect;
  logic [PC_W-1:0]  link_addr;
  logic             illegal_branch;
  logic             halted;
  logic [CNT_W-1:0] instret;

  fetch_sequencer #(
    .PC_W     (PC_W),
    .RESET_PC (12'h000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .halt_req       (halt_req),
    .resume         (resume),
    .opcode_ex      (opcode_ex),
    .funct3_ex      (funct3_ex),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .branch_addr    (branch_addr),
    .jal_addr       (jal_addr),
    .jalr_addr      (jalr_addr),
    .pc_f           (pc_f),
    .pc_ex          (pc_ex),
    .ex_valid       (ex_valid),
    .redirect       (redirect),
    .link_addr      (link_addr),
    .illegal_branch (illegal_branch),
    .halted         (halted),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string  name;
    longint pc_f;
    longint pc_ex;
    longint ev;
    longint redir;
    longint link;
    longint ill;
    longint halt;
    longint inst;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string nm, input string fld,
                       input longint act, input longint exp_v);
    if (exp_v < 0) return;
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp_v);
  endtask

  // Monitor: compares the DUT against the oldest expectation each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check(mon_e.name, "pc_f",     longint'(pc_f),           mon_e.pc_f);
        check(mon_e.name, "pc_ex",    longint'(pc_ex),          mon_e.pc_ex);
        check(mon_e.name, "ex_valid", longint'(ex_valid),       mon_e.ev);
        check(mon_e.name, "redirect", longint'(redirect),       mon_e.redir);
        check(mon_e.name, "link",     longint'(link_addr),      mon_e.link);
        check(mon_e.name, "illegal",  longint'(illegal_branch), mon_e.ill);
        check(mon_e.name, "halted",   longint'(halted),         mon_e.halt);
        check(mon_e.name, "instret",  longint'(instret),        mon_e.inst);
      end
    end
  end

  // One cycle: drive inputs, queue the expectation, advance to just after
  // the next rising edge.
  task automatic cyc(input string nm,
                     input logic rn, input logic st, input logic hr, input logic rs,
                     input logic [6:0] op, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [11:0] ba, input logic [11:0] ja, input logic [11:0] jra,
                     input longint e_pcf, input longint e_pcex, input longint e_ev,
                     input longint e_red, input longint e_link, input longint e_ill,
                     input longint e_halt, input longint e_inst);
    exp_t e;
    rst_n = rn; stall = st; halt_req = hr; resume = rs;
    opcode_ex = op; funct3_ex = f3; rs1_data = a; rs2_data = b;
    branch_addr = ba; jal_addr = ja; jalr_addr = jra;
    e.name = nm;   e.pc_f = e_pcf; e.pc_ex = e_pcex; e.ev = e_ev;
    e.redir = e_red; e.link = e_link; e.ill = e_ill; e.halt = e_halt; e.inst = e_inst;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] NOP = 7'b0010011;

  initial begin
    rst_n = 1'b0; stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
    opcode_ex = NOP; funct3_ex = 3'b000; rs1_data = '0; rs2_data = '0;
    branch_addr = '0; jal_addr = '0; jalr_addr = '0;
    @(posedge clk); #1;

    //   name          rn st hr rs  opcode      f3   rs1           rs2    ba      ja      jra      pc_f    pc_ex   ev red link    ill hlt inst
    cyc("reset",       0, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h000, 'h000, 0, 0, 'h001, 0, 0, 0);
    cyc("release",     1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h000, 'h000, 0, 0, 'h001, 0, 0, 0);
    cyc("run1",        1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h001, 'h000, 1, 0, 'h001, 0, 0, 0);
    cyc("run2",        1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h002, 'h001, 1, 0, 'h002, 0, 0, 1);
    cyc("run3",        1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h003, 'h002, 1, 0, 'h003, 0, 0, 2);
    cyc("run4",        1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h004, 'h003, 1, 0, 'h004, 0, 0, 3);
    cyc("run5",        1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h005, 'h004, 1, 0, 'h005, 0, 0, 4);
    cyc("beq_take",    1, 0, 0, 0, OPC_BRANCH, F3_BEQ, 32'd7,      32'd7, 12'h020, 12'h000, 12'h000, 'h006, 'h005, 1, 1, 'h006, 0, 0, 5);
    cyc("beq_bubble",  1, 0, 0, 0, OPC_BRANCH, F3_BEQ, 32'd7,      32'd7, 12'h020, 12'h000, 12'h000, 'h020, 'h006, 0, 0, 'h007, 0, 0, 6);
    cyc("bltu_nt",     1, 0, 0, 0, OPC_BRANCH, F3_BLTU, 32'hFFFFFFFF, 32'd1, 12'h080, 12'h000, 12'h000, 'h021, 'h020, 1, 0, 'h021, 0, 0, 6);
    cyc("blt_take",    1, 0, 0, 0, OPC_BRANCH, F3_BLT, 32'hFFFFFFFF, 32'd1, 12'h080, 12'h000, 12'h000, 'h022, 'h021, 1, 1, 'h022, 0, 0, 7);
    cyc("blt_bubble",  1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h080, 12'h000, 12'h000, 'h080, 'h022, 0, 0, 'h023, 0, 0, 8);
    cyc("illegal_f3",  1, 0, 0, 0, OPC_BRANCH, 3'b010, 32'd5,      32'd5, 12'h080, 12'h000, 12'h000, 'h081, 'h080, 1, 0, 'h081, 1, 0, 8);
    cyc("jalr_stall1", 1, 1, 0, 0, OPC_JALR,   3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h100, 'h082, 'h081, 1, 0, 'h082, 0, 0, 9);
    cyc("jalr_stall2", 1, 1, 0, 0, OPC_JALR,   3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h100, 'h082, 'h081, 1, 0, 'h082, 0, 0, 9);
    cyc("jalr_stall3", 1, 1, 0, 0, OPC_JALR,   3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h100, 'h082, 'h081, 1, 0, 'h082, 0, 0, 9);
    cyc("jalr_go",     1, 0, 0, 0, OPC_JALR,   3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h100, 'h082, 'h081, 1, 1, 'h082, 0, 0, 9);
    cyc("jalr_bubble", 1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h100, 'h100, 'h082, 0, 0, 'h083, 0, 0, 10);
    cyc("bgeu_nt",     1, 0, 0, 0, OPC_BRANCH, F3_BGEU, 32'd3,     32'd5, 12'h300, 12'h000, 12'h000, 'h101, 'h100, 1, 0, 'h101, 0, 0, 10);
    cyc("jal_fff",     1, 0, 0, 0, OPC_JAL,    3'd0, 32'd0,        32'd0, 12'h000, 12'hFFF, 12'h000, 'h102, 'h101, 1, 1, 'h102, 0, 0, 11);
    cyc("at_fff",      1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'hFFF, 'h102, 0, 0, 'h103, 0, 0, 12);
    cyc("wrapped",     1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h000, 'hFFF, 1, 0, 'h000, 0, 0, 12);
    cyc("jal_halt",    1, 0, 1, 0, OPC_JAL,    3'd0, 32'd0,        32'd0, 12'h000, 12'h040, 12'h000, 'h001, 'h000, 1, 1, 'h001, 0, 0, 13);
    cyc("halt_stall",  1, 1, 0, 0, OPC_JAL,    3'd0, 32'd0,        32'd0, 12'h000, 12'h040, 12'h000, 'h040, D,     0, 0, D,     0, 1, 14);
    cyc("resume_both", 1, 0, 1, 1, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h040, D,     0, 0, D,     0, 1, 14);
    cyc("resume_gap",  1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h040, D,     0, 0, D,     0, 0, 14);
    cyc("resumed",     1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h041, 'h040, 1, 0, 'h041, 0, 0, 14);
    cyc("halt_seq",    1, 0, 1, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h042, 'h041, 1, 0, 'h042, 0, 0, 15);
    cyc("halted_seq",  1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h043, D,     0, 0, D,     0, 1, 16);
    cyc("rst_mid",     0, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h000, 'h000, 0, 0, 'h001, 0, 0, 0);
    cyc("rst_rel",     1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h000, 'h000, 0, 0, 'h001, 0, 0, 0);
    cyc("after_rst",   1, 0, 0, 0, NOP,        3'd0, 32'd0,        32'd0, 12'h000, 12'h000, 12'h000, 'h001, 'h000, 1, 0, 'h001, 0, 0, 0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
